// File: rtl/uart_pkg.sv
// Shared UART constants and divisor type, used by the baud generator and the TX/RX paths.
package uart_pkg;

  localparam int UART_DIV_W      = 16;
  localparam int UART_FRAC_W     = 4;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DEF_INT    = 27;
  localparam int UART_DEF_FRAC   = 2;
  localparam int UART_MIN_DIV    = 2;

  typedef struct packed {
    logic [UART_DIV_W-1:0]  div_int;
    logic [UART_FRAC_W-1:0] div_frac;
  } uart_div_t;

endpackage

// File: rtl/uart_frac_div.sv
// Fractional prescaler: period counter, phase accumulator and double-buffered divisor.
// Emits a one-cycle combinational wrap strobe at the last cycle of each period.
module uart_frac_div
  import uart_pkg::*;
#(
  parameter int DIV_W    = UART_DIV_W,
  parameter int FRAC_W   = UART_FRAC_W,
  parameter int DEF_INT  = UART_DEF_INT,
  parameter int DEF_FRAC = UART_DEF_FRAC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              sync_clr,
  output logic              wrap,
  output logic              load_ok,
  output logic              load_rej
);

  typedef struct packed {
    logic [DIV_W-1:0]  i;
    logic [FRAC_W-1:0] f;
  } div_t;

  div_t              act;
  div_t              shd;
  logic              pending;
  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   acc_sum;
  logic [DIV_W:0]    last_cnt;

  // Carry out of the accumulator stretches this period by one cycle.
  assign acc_sum  = {1'b0, acc} + {1'b0, act.f};
  assign last_cnt = {1'b0, act.i} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]}
                  - {{DIV_W{1'b0}}, 1'b1};

  // >= rather than == so an immediate reload to a shorter divisor cannot strand cnt.
  assign wrap     = enable && !sync_clr && ({1'b0, cnt} >= last_cnt);
  assign load_ok  = div_load && (div_int >= DIV_W'(UART_MIN_DIV));
  assign load_rej = div_load && !load_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      acc     <= '0;
      act     <= '{i: DIV_W'(DEF_INT), f: FRAC_W'(DEF_FRAC)};
      shd     <= '{i: DIV_W'(DEF_INT), f: FRAC_W'(DEF_FRAC)};
      pending <= 1'b0;
    end else begin
      if (sync_clr) begin
        cnt <= '0;
        acc <= '0;
      end else if (wrap) begin
        cnt <= '0;
        acc <= acc_sum[FRAC_W-1:0];
      end else if (enable) begin
        cnt <= cnt + 1'b1;
      end

      if (wrap && pending) begin
        act     <= shd;
        pending <= 1'b0;
      end

      // A load landing on a wrap edge is buffered for the following period.
      if (load_ok) begin
        if (!enable || sync_clr) begin
          act     <= '{i: div_int, f: div_frac};
          pending <= 1'b0;
        end else begin
          shd     <= '{i: div_int, f: div_frac};
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Fractional baud generator: oversample tick, bit tick and bit-rate square wave T_clk,
// with enable, glitch-free divisor reload, RX mid-bit resync and sticky config error.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W      = UART_DIV_W,
  parameter int FRAC_W     = UART_FRAC_W,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DEF_INT    = UART_DEF_INT,
  parameter int DEF_FRAC   = UART_DEF_FRAC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              sync_clr,
  output logic              tick_os,
  output logic              tick_bit,
  output logic              T_clk,
  output logic              cfg_err
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

  logic            wrap;
  logic            load_ok;
  logic            load_rej;
  logic [OS_W-1:0] os_cnt;

  uart_frac_div #(
    .DIV_W    (DIV_W),
    .FRAC_W   (FRAC_W),
    .DEF_INT  (DEF_INT),
    .DEF_FRAC (DEF_FRAC)
  ) u_frac_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .sync_clr (sync_clr),
    .wrap     (wrap),
    .load_ok  (load_ok),
    .load_rej (load_rej)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_cnt   <= '0;
      tick_os  <= 1'b0;
      tick_bit <= 1'b0;
      T_clk    <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      tick_os  <= wrap;
      tick_bit <= wrap && (os_cnt == OS_LAST);

      // Resync lands mid-bit so the first bit tick samples the centre of the start bit.
      if (sync_clr) begin
        os_cnt <= OS_HALF;
        T_clk  <= 1'b1;
      end else if (wrap) begin
        if (os_cnt == OS_LAST) begin
          os_cnt <= '0;
          T_clk  <= 1'b0;
        end else begin
          os_cnt <= os_cnt + 1'b1;
          if (os_cnt == OS_HALF - 1'b1) T_clk <= 1'b1;
        end
      end

      if (load_rej)     cfg_err <= 1'b1;
      else if (load_ok) cfg_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: tick spacing, reload, cfg error, resync, enable, reset.
module tb_uart_baud_gen;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        sync_clr;
  logic        tick_os;
  logic        tick_bit;
  logic        T_clk;
  logic        cfg_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int c0          = 0;
  int t_last      = 0;

  uart_baud_gen dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .sync_clr (sync_clr),
    .tick_os  (tick_os),
    .tick_bit (tick_bit),
    .T_clk    (T_clk),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_os(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick_os === 1'b1) begin
        t = cyc;
        t_last = cyc;
        return;
      end
    end
  endtask

  task automatic wait_bit(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick_bit === 1'b1) begin
        t = cyc;
        t_last = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    enable   = 1'b0;
    div_int  = 16'd0;
    div_frac = 4'd0;
    div_load = 1'b0;
    sync_clr = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({tick_os, tick_bit, T_clk, cfg_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 0000", {tick_os, tick_bit, T_clk, cfg_err});
    end
    reset_n = 1'b1;
    enable  = 1'b1;
    c0      = cyc;
  endtask

  task automatic test_default_rate();
    int t, tprev, t_rise, t_rise2, t_fall, tb15, tb31, exp_d;
    bit exp_bit, exp_tclk;
    tprev = c0;
    t_rise = 0; t_rise2 = 0; t_fall = 0; tb15 = 0; tb31 = 0;
    for (int k = 0; k < 32; k++) begin
      wait_os(60, t);
      exp_d    = (k % 8 == 7) ? 28 : 27;
      exp_bit  = (k % 16 == 15);
      exp_tclk = (((k + 1) % 16) >= 8);
      vectors++;
      if (t - tprev !== exp_d) begin
        miscompares++;
        $display("FAIL default_period[%0d]: got %0d expected %0d", k, t - tprev, exp_d);
      end
      vectors++;
      if (tick_bit !== exp_bit) begin
        miscompares++;
        $display("FAIL default_tick_bit[%0d]: got %b expected %b", k, tick_bit, exp_bit);
      end
      vectors++;
      if (T_clk !== exp_tclk) begin
        miscompares++;
        $display("FAIL default_T_clk[%0d]: got %b expected %b", k, T_clk, exp_tclk);
      end
      if (k == 7)  t_rise  = t;
      if (k == 15) begin t_fall = t; tb15 = t; end
      if (k == 23) t_rise2 = t;
      if (k == 31) tb31 = t;
      tprev = t;
    end
    vectors++;
    if (tb31 - tb15 !== 434) begin
      miscompares++;
      $display("FAIL bit_spacing: got %0d expected 434", tb31 - tb15);
    end
    vectors++;
    if (t_fall - t_rise !== 217) begin
      miscompares++;
      $display("FAIL T_clk_high: got %0d expected 217", t_fall - t_rise);
    end
    vectors++;
    if (t_rise2 - t_rise !== 434) begin
      miscompares++;
      $display("FAIL T_clk_period: got %0d expected 434", t_rise2 - t_rise);
    end
  endtask

  task automatic test_reload();
    int t, tprev, tb_first, tb_second;
    tprev = t_last;
    tb_first = -1;
    tb_second = -1;
    repeat (5) @(negedge clk);
    div_int  = 16'd4;
    div_frac = 4'd0;
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    wait_os(60, t);
    vectors++;
    if (t - tprev !== 27) begin
      miscompares++;
      $display("FAIL reload_old_period: got %0d expected 27", t - tprev);
    end
    tprev = t;
    @(negedge clk);
    vectors++;
    if (tick_os !== 1'b0) begin
      miscompares++;
      $display("FAIL tick_os_width: got %b expected 0", tick_os);
    end
    for (int k = 0; k < 39; k++) begin
      wait_os(20, t);
      vectors++;
      if (t - tprev !== 4) begin
        miscompares++;
        $display("FAIL reload_new_period[%0d]: got %0d expected 4", k, t - tprev);
      end
      if (tick_bit === 1'b1) begin
        if (tb_first < 0) tb_first = t;
        else if (tb_second < 0) tb_second = t;
      end
      tprev = t;
    end
    vectors++;
    if (tb_second - tb_first !== 64) begin
      miscompares++;
      $display("FAIL reload_bit_spacing: got %0d expected 64", tb_second - tb_first);
    end
  endtask

  task automatic test_cfg_err();
    int t, tprev;
    int exp_d[3] = '{4, 8, 8};
    tprev = t_last;
    div_int  = 16'd1;
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_err_set: got %b expected 1", cfg_err);
    end
    for (int k = 0; k < 2; k++) begin
      wait_os(20, t);
      vectors++;
      if (t - tprev !== 4) begin
        miscompares++;
        $display("FAIL cfg_err_period[%0d]: got %0d expected 4", k, t - tprev);
      end
      tprev = t;
    end
    div_int  = 16'd8;
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    vectors++;
    if (cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_err_clear: got %b expected 0", cfg_err);
    end
    for (int k = 0; k < 3; k++) begin
      wait_os(20, t);
      vectors++;
      if (t - tprev !== exp_d[k]) begin
        miscompares++;
        $display("FAIL div8_period[%0d]: got %0d expected %0d", k, t - tprev, exp_d[k]);
      end
      tprev = t;
    end
  endtask

  task automatic test_sync_clr();
    int t, tprev, cs;
    tprev = t_last;
    div_int  = 16'd4;
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    wait_os(20, t);
    wait_os(20, t);
    vectors++;
    if (t - tprev !== 12) begin
      miscompares++;
      $display("FAIL sync_setup: got %0d expected 12", t - tprev);
    end
    @(negedge clk);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    cs = cyc;
    vectors++;
    if ({T_clk, tick_os} !== 2'b10) begin
      miscompares++;
      $display("FAIL sync_T_clk: got %b expected 10", {T_clk, tick_os});
    end
    wait_bit(100, t);
    vectors++;
    if (t - cs !== 32) begin
      miscompares++;
      $display("FAIL sync_first_bit: got %0d expected 32", t - cs);
    end
    tprev = t;
    wait_bit(150, t);
    vectors++;
    if (t - tprev !== 64) begin
      miscompares++;
      $display("FAIL sync_bit_spacing: got %0d expected 64", t - tprev);
    end
    @(negedge clk);
    sync_clr = 1'b1;
    div_load = 1'b1;
    div_int  = 16'd6;
    @(negedge clk);
    sync_clr = 1'b0;
    div_load = 1'b0;
    cs = cyc;
    wait_os(20, t);
    vectors++;
    if (t - cs !== 6) begin
      miscompares++;
      $display("FAIL sync_load_first: got %0d expected 6", t - cs);
    end
    tprev = t;
    wait_os(20, t);
    vectors++;
    if (t - tprev !== 6) begin
      miscompares++;
      $display("FAIL sync_load_second: got %0d expected 6", t - tprev);
    end
    wait_bit(100, t);
    vectors++;
    if (t - cs !== 48) begin
      miscompares++;
      $display("FAIL sync_load_bit: got %0d expected 48", t - cs);
    end
  endtask

  task automatic test_enable();
    int t, tprev, c1, pulses;
    bit t_clk_held;
    for (int k = 0; k < 9; k++) wait_os(20, t);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    pulses = 0;
    t_clk_held = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tick_os === 1'b1 || tick_bit === 1'b1) pulses++;
      if (T_clk !== 1'b1) t_clk_held = 1'b0;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL frozen_ticks: got %0d expected 0", pulses);
    end
    vectors++;
    if (t_clk_held !== 1'b1) begin
      miscompares++;
      $display("FAIL frozen_T_clk: got %b expected 1", t_clk_held);
    end
    enable = 1'b1;
    c1 = cyc;
    wait_os(20, t);
    vectors++;
    if (t - c1 !== 4) begin
      miscompares++;
      $display("FAIL resume_remaining: got %0d expected 4", t - c1);
    end
    tprev = t;
    wait_os(20, t);
    vectors++;
    if (t - tprev !== 6) begin
      miscompares++;
      $display("FAIL resume_period: got %0d expected 6", t - tprev);
    end
  endtask

  task automatic test_async_reset();
    int t, tprev, exp_d;
    @(negedge clk);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    div_load = 1'b1;
    div_int  = 16'd4;
    @(negedge clk);
    div_int  = 16'd1;
    @(negedge clk);
    div_load = 1'b0;
    vectors++;
    if ({T_clk, cfg_err} !== 2'b11) begin
      miscompares++;
      $display("FAIL pre_reset_state: got %b expected 11", {T_clk, cfg_err});
    end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({tick_os, tick_bit, T_clk, cfg_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got %b expected 0000", {tick_os, tick_bit, T_clk, cfg_err});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    tprev = cyc;
    for (int k = 0; k < 8; k++) begin
      wait_os(60, t);
      exp_d = (k == 7) ? 28 : 27;
      vectors++;
      if (t - tprev !== exp_d) begin
        miscompares++;
        $display("FAIL post_reset_period[%0d]: got %0d expected %0d", k, t - tprev, exp_d);
      end
      tprev = t;
    end
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_reload();
    test_cfg_err();
    test_sync_clr();
    test_enable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
